// File: rtl/chroni_pixel_out_pkg.sv
// Shared constants and types for the chroni pixel output stage:
// RGB565 field positions, palette geometry and palette-write FSM states.
package chroni_pixel_out_pkg;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   localparam int PAL_ENTRIES = 256;
   localparam int PAL_AW      = $clog2(PAL_ENTRIES);

   typedef enum logic {
      PAL_IDLE = 1'b0,
      PAL_HOLD = 1'b1
   } pal_state_t;

   typedef struct packed {
      logic [R_MSB-R_LSB:0] r;
      logic [G_MSB-G_LSB:0] g;
      logic [B_MSB-B_LSB:0] b;
   } rgb565_t;

   function automatic rgb565_t split_rgb565(input logic [15:0] c);
      rgb565_t v;
      v.r = c[R_MSB:R_LSB];
      v.g = c[G_MSB:G_LSB];
      v.b = c[B_MSB:B_LSB];
      return v;
   endfunction

endpackage

// File: rtl/chroni_palette_ram.sv
// 256x16 palette store: one write port, one registered read port.
// A read and write to the same address on one edge returns the old data.
module chroni_palette_ram
   import chroni_pixel_out_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [PAL_AW-1:0] i_waddr,
   input  logic [15:0]       i_wdata,
   input  logic [PAL_AW-1:0] i_raddr,
   output logic [15:0]       o_rdata
);

   logic [15:0] r_mem [PAL_ENTRIES];
   logic [15:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/chroni_pixel_out.sv
// Final chroni video stage: palette lookup, border/blank mux, sync polarity,
// tear-free deferred palette writes, and the vblank pulse / frame counter.
module chroni_pixel_out
   import chroni_pixel_out_pkg::*;
#(
   parameter int PAL_DEFER  = 1,
   parameter int FRAME_BITS = 16
)
(
   input  logic                  vga_clk,
   input  logic                  reset_n,
   input  logic                  de_in,
   input  logic                  pf_in,
   input  logic                  hs_act_in,
   input  logic                  vs_act_in,
   input  logic                  h_pol,
   input  logic                  v_pol,
   input  logic [7:0]            pixel_in,
   input  logic                  border_we,
   input  logic [15:0]           border_data,
   input  logic                  pal_we,
   input  logic [7:0]            pal_addr,
   input  logic [15:0]           pal_data,
   output logic                  pal_ready,
   output logic                  vga_hs,
   output logic                  vga_vs,
   output logic [4:0]            vga_r,
   output logic [5:0]            vga_g,
   output logic [4:0]            vga_b,
   output logic                  vblank_pulse,
   output logic [FRAME_BITS-1:0] frame_cnt
);

   pal_state_t        r_state;
   pal_state_t        w_state_next;
   logic [7:0]        r_hold_addr;
   logic [15:0]       r_hold_data;
   logic              w_capture;
   logic              w_ram_we;
   logic [7:0]        w_ram_addr;
   logic [15:0]       w_ram_data;
   logic [15:0]       w_pal_q;

   logic              r_de_d;
   logic              r_pf_d;
   logic              r_hs_d;
   logic              r_vs_d;
   logic [15:0]       r_border;
   logic [15:0]       r_border_d;
   logic [15:0]       w_color;
   rgb565_t           w_rgb;
   logic              w_vs_rise;

   logic [4:0]        r_r;
   logic [5:0]        r_g;
   logic [4:0]        r_b;
   logic              r_hs;
   logic              r_vs;
   logic              r_vblank;
   logic [FRAME_BITS-1:0] r_frame_cnt;

   chroni_palette_ram u_pal_ram (
      .i_clk   (vga_clk),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_addr),
      .i_wdata (w_ram_data),
      .i_raddr (pixel_in),
      .o_rdata (w_pal_q)
   );

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         r_state <= PAL_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (w_capture) begin
         r_hold_addr <= pal_addr;
         r_hold_data <= pal_data;
      end
   end

   // A write arriving during active display is parked until blanking so a line never tears.
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_ram_we     = 1'b0;
      w_ram_addr   = pal_addr;
      w_ram_data   = pal_data;
      case (r_state)
         PAL_IDLE: begin
            if (pal_we) begin
               if (de_in && (PAL_DEFER != 0)) begin
                  w_capture    = 1'b1;
                  w_state_next = PAL_HOLD;
               end else begin
                  w_ram_we = 1'b1;
               end
            end
         end
         PAL_HOLD: begin
            if (!de_in) begin
               w_ram_we     = 1'b1;
               w_ram_addr   = r_hold_addr;
               w_ram_data   = r_hold_data;
               w_state_next = PAL_IDLE;
            end
         end
         default: w_state_next = PAL_IDLE;
      endcase
      if (!reset_n) begin
         w_ram_we = 1'b0;
      end
   end

   // Border is delayed with the pixel so a border change applies only to later pixels.
   assign w_color   = r_de_d ? (r_pf_d ? w_pal_q : r_border_d) : 16'h0000;
   assign w_rgb     = split_rgb565(w_color);
   assign w_vs_rise = vs_act_in & ~r_vs_d;

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         r_de_d      <= 1'b0;
         r_pf_d      <= 1'b0;
         r_hs_d      <= 1'b0;
         r_vs_d      <= 1'b0;
         r_border    <= 16'h0000;
         r_border_d  <= 16'h0000;
         r_r         <= '0;
         r_g         <= '0;
         r_b         <= '0;
         r_hs        <= ~h_pol;
         r_vs        <= ~v_pol;
         r_vblank    <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         if (border_we) begin
            r_border <= border_data;
         end
         r_de_d     <= de_in;
         r_pf_d     <= pf_in;
         r_hs_d     <= hs_act_in;
         r_vs_d     <= vs_act_in;
         r_border_d <= r_border;
         r_r        <= w_rgb.r;
         r_g        <= w_rgb.g;
         r_b        <= w_rgb.b;
         r_hs       <= r_hs_d ? h_pol : ~h_pol;
         r_vs       <= r_vs_d ? v_pol : ~v_pol;
         r_vblank   <= w_vs_rise;
         if (w_vs_rise) begin
            r_frame_cnt <= r_frame_cnt + FRAME_BITS'(1);
         end
      end
   end

   assign pal_ready    = (r_state == PAL_IDLE);
   assign vga_r        = r_r;
   assign vga_g        = r_g;
   assign vga_b        = r_b;
   assign vga_hs       = r_hs;
   assign vga_vs       = r_vs;
   assign vblank_pulse = r_vblank;
   assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_chroni_pixel_out.sv
// Self-checking bench for chroni_pixel_out: directed table, hand sequences for
// deferral / sync width / frame wrap / reset-in-HOLD, then randomized traffic vs a reference model.
module tb_chroni_pixel_out;

   localparam int FB = 4;

   logic          vga_clk = 1'b0;
   logic          reset_n;
   logic          de_in, pf_in, hs_act_in, vs_act_in, h_pol, v_pol;
   logic [7:0]    pixel_in;
   logic          border_we;
   logic [15:0]   border_data;
   logic          pal_we;
   logic [7:0]    pal_addr;
   logic [15:0]   pal_data;
   logic          pal_ready, vga_hs, vga_vs, vblank_pulse;
   logic [4:0]    vga_r;
   logic [5:0]    vga_g;
   logic [4:0]    vga_b;
   logic [FB-1:0] frame_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [15:0] pal_m [256];
   logic [15:0] border_m;
   bit          pend_v;
   logic [7:0]  pend_a;
   logic [15:0] pend_d;
   bit          vs_prev;
   int          frames;
   bit          vbl_m;
   logic [15:0] s_col;
   bit          s_hs, s_vs;
   logic [15:0] e_col;
   bit          e_hs, e_vs;

   typedef struct {
      bit          de;
      bit          pf;
      logic [7:0]  pix;
      bit          hs;
      logic [15:0] exp_col;
      bit          exp_hs;
   } vec_t;

   vec_t tbl [6];

   chroni_pixel_out #(.PAL_DEFER(1), .FRAME_BITS(FB)) dut (
      .vga_clk      (vga_clk),
      .reset_n      (reset_n),
      .de_in        (de_in),
      .pf_in        (pf_in),
      .hs_act_in    (hs_act_in),
      .vs_act_in    (vs_act_in),
      .h_pol        (h_pol),
      .v_pol        (v_pol),
      .pixel_in     (pixel_in),
      .border_we    (border_we),
      .border_data  (border_data),
      .pal_we       (pal_we),
      .pal_addr     (pal_addr),
      .pal_data     (pal_data),
      .pal_ready    (pal_ready),
      .vga_hs       (vga_hs),
      .vga_vs       (vga_vs),
      .vga_r        (vga_r),
      .vga_g        (vga_g),
      .vga_b        (vga_b),
      .vblank_pulse (vblank_pulse),
      .frame_cnt    (frame_cnt)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply the current inputs for one clock edge, advance the model, then check all outputs.
   task automatic cycle();
      logic [15:0] col;
      if (reset_n && pal_we) chk("pal_we_protocol", 32'(pal_ready), 32'd1);
      col = de_in ? (pf_in ? pal_m[pixel_in] : border_m) : 16'h0000;
      if (!reset_n) begin
         e_col = 16'h0; e_hs = ~h_pol; e_vs = ~v_pol;
         s_col = 16'h0; s_hs = 1'b0; s_vs = 1'b0;
         pend_v = 1'b0; border_m = 16'h0; vs_prev = 1'b0; frames = 0; vbl_m = 1'b0;
      end else begin
         e_col = s_col;
         e_hs  = s_hs ? h_pol : ~h_pol;
         e_vs  = s_vs ? v_pol : ~v_pol;
         s_col = col; s_hs = hs_act_in; s_vs = vs_act_in;
         vbl_m = vs_act_in && !vs_prev;
         if (vbl_m) frames = (frames + 1) % (1 << FB);
         vs_prev = vs_act_in;
         if (border_we) border_m = border_data;
         if (pend_v) begin
            if (!de_in) begin
               pal_m[pend_a] = pend_d;
               pend_v = 1'b0;
            end
         end else if (pal_we) begin
            if (de_in) begin
               pend_v = 1'b1; pend_a = pal_addr; pend_d = pal_data;
            end else begin
               pal_m[pal_addr] = pal_data;
            end
         end
      end
      @(posedge vga_clk);
      @(negedge vga_clk);
      chk("rgb",       32'({vga_r, vga_g, vga_b}), 32'(e_col));
      chk("hs",        32'(vga_hs), 32'(e_hs));
      chk("vs",        32'(vga_vs), 32'(e_vs));
      chk("pal_ready", 32'(pal_ready), 32'(!pend_v));
      chk("vblank",    32'(vblank_pulse), 32'(vbl_m));
      chk("frame_cnt", 32'(frame_cnt), 32'(frames));
   endtask

   initial begin
      int low_cnt, first_low, vbl_cnt;

      tbl[0] = '{de:1'b1, pf:1'b1, pix:8'd5,   hs:1'b0, exp_col:16'hF800, exp_hs:1'b0};
      tbl[1] = '{de:1'b1, pf:1'b0, pix:8'd5,   hs:1'b1, exp_col:16'h001F, exp_hs:1'b1};
      tbl[2] = '{de:1'b0, pf:1'b1, pix:8'd5,   hs:1'b0, exp_col:16'h0000, exp_hs:1'b0};
      tbl[3] = '{de:1'b1, pf:1'b1, pix:8'h10,  hs:1'b1, exp_col:16'h10EF, exp_hs:1'b1};
      tbl[4] = '{de:1'b1, pf:1'b1, pix:8'hFF,  hs:1'b0, exp_col:16'hFF00, exp_hs:1'b0};
      tbl[5] = '{de:1'b0, pf:1'b0, pix:8'h00,  hs:1'b1, exp_col:16'h0000, exp_hs:1'b1};

      for (int i = 0; i < 256; i++) pal_m[i] = 16'h0000;
      reset_n = 1'b0; de_in = 1'b0; pf_in = 1'b0; hs_act_in = 1'b0; vs_act_in = 1'b0;
      h_pol = 1'b1; v_pol = 1'b1; pixel_in = 8'h00; border_we = 1'b0; border_data = 16'h0;
      pal_we = 1'b0; pal_addr = 8'h00; pal_data = 16'h0;
      @(negedge vga_clk);
      for (int i = 0; i < 3; i++) cycle();
      chk("reset_hs", 32'(vga_hs), 32'd0);
      chk("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
      reset_n = 1'b1;

      // Fill the palette during blanking: entry i = {i, ~i}
      for (int i = 0; i < 256; i++) begin
         pal_we = 1'b1; pal_addr = 8'(i); pal_data = {8'(i), ~8'(i)};
         cycle();
      end
      // Test 1 preconditions: pal[5]=red, border=blue
      pal_addr = 8'd5; pal_data = 16'hF800;
      border_we = 1'b1; border_data = 16'h001F;
      cycle();
      pal_we = 1'b0; border_we = 1'b0;

      for (int i = 0; i < 6; i++) begin
         de_in = tbl[i].de; pf_in = tbl[i].pf; pixel_in = tbl[i].pix; hs_act_in = tbl[i].hs;
         cycle();
         cycle();
         chk($sformatf("tbl%0d_rgb", i), 32'({vga_r, vga_g, vga_b}), 32'(tbl[i].exp_col));
         chk($sformatf("tbl%0d_hs", i), 32'(vga_hs), 32'(tbl[i].exp_hs));
      end
      hs_act_in = 1'b0;

      // Deferred write during active display
      de_in = 1'b1; pf_in = 1'b1; pixel_in = 8'd5;
      pal_we = 1'b1; pal_addr = 8'd5; pal_data = 16'h07E0;
      cycle();
      pal_we = 1'b0;
      chk("defer_ready_low", 32'(pal_ready), 32'd0);
      for (int i = 0; i < 3; i++) cycle();
      chk("defer_old_color", 32'({vga_r, vga_g, vga_b}), 32'hF800);
      de_in = 1'b0;
      cycle();
      chk("defer_ready_back", 32'(pal_ready), 32'd1);
      de_in = 1'b1;
      cycle();
      cycle();
      chk("defer_new_g", 32'(vga_g), 32'h3F);
      chk("defer_new_color", 32'({vga_r, vga_g, vga_b}), 32'h07E0);
      de_in = 1'b0;

      // hsync width with active-low polarity
      h_pol = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      low_cnt = 0; first_low = -1;
      for (int i = 0; i < 120; i++) begin
         hs_act_in = (i < 96);
         cycle();
         if (vga_hs == 1'b0) begin
            low_cnt++;
            if (first_low < 0) first_low = i;
         end
      end
      chk("hs_low_width", 32'(low_cnt), 32'd96);
      chk("hs_first_low", 32'(first_low), 32'd1);
      h_pol = 1'b1; hs_act_in = 1'b0;
      cycle();

      // Frame counter wrap with FRAME_BITS=4
      vbl_cnt = 0;
      for (int f = 0; f < 18; f++) begin
         for (int c = 0; c < 4; c++) begin
            vs_act_in = (c < 2);
            cycle();
            if (vblank_pulse) vbl_cnt++;
         end
         if (f == 14) chk("frame_15", 32'(frame_cnt), 32'd15);
         if (f == 15) chk("frame_wrap", 32'(frame_cnt), 32'd0);
      end
      chk("vblank_count", 32'(vbl_cnt), 32'd18);
      chk("frame_final", 32'(frame_cnt), 32'd2);
      vs_act_in = 1'b0;

      // Reset while a deferred write is held
      de_in = 1'b1; pal_we = 1'b1; pal_addr = 8'd9; pal_data = 16'h1234;
      cycle();
      pal_we = 1'b0;
      chk("hold_ready_low", 32'(pal_ready), 32'd0);
      reset_n = 1'b0; de_in = 1'b0;
      cycle();
      chk("rst_hold_ready", 32'(pal_ready), 32'd1);
      chk("rst_hold_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
      chk("rst_hold_frame", 32'(frame_cnt), 32'd0);
      reset_n = 1'b1; de_in = 1'b1; pf_in = 1'b1; pixel_in = 8'd9;
      cycle();
      cycle();
      chk("rst_hold_ram_kept", 32'({vga_r, vga_g, vga_b}), 32'h09F6);

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         reset_n     = ($urandom_range(0, 199) != 0);
         de_in       = ($urandom_range(0, 9) < 6);
         pf_in       = ($urandom_range(0, 3) != 0);
         pixel_in    = 8'($urandom);
         hs_act_in   = ($urandom_range(0, 4) == 0);
         vs_act_in   = ($urandom_range(0, 6) == 0);
         if ($urandom_range(0, 49) == 0) h_pol = ~h_pol;
         if ($urandom_range(0, 49) == 0) v_pol = ~v_pol;
         border_we   = ($urandom_range(0, 19) == 0);
         border_data = 16'($urandom);
         pal_we      = !pend_v && ($urandom_range(0, 7) == 0);
         pal_addr    = 8'($urandom);
         pal_data    = 16'($urandom);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
